// File: rtl/insn_fetch_seq_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and
// the instruction memory (slave).
interface insn_fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/insn_fetch_seq.sv
// Instruction fetch sequencer: IDLE -> FETCH -> EXEC -> FETCH ... with a
// terminal HALT on an illegal opcode or a memory that never acknowledges.
// The fetched word and its one-hot opcode class are held for the decoders
// for the whole EXEC phase.
module insn_fetch_seq #(
    parameter int unsigned EXEC_CYCLES = 2,   // 1..15
    parameter int unsigned ACK_TIMEOUT = 15   // 1..255
) (
    input  logic                clk,
    input  logic                rst_n,
    insn_fetch_seq_if.master    imem,
    input  logic [31:0]         pc_i,
    input  logic                stall_i,
    output logic [31:0]         insn_o,
    output logic [9:0]          code_o,
    output logic                exec_en_o,
    output logic                pc_load_o,
    output logic                fault_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [9:0]  NOP_CODE  = 10'b00_1000_0000;
    localparam logic [3:0]  EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [7:0]  TMO_LIMIT = 8'(ACK_TIMEOUT);

    // One-hot opcode class from bits [6:0]; bit 9 flags an illegal opcode.
    function automatic logic [9:0] decode(input logic [31:0] w);
        case (w[6:0])
            7'b0000011: decode = 10'b01_0000_0000; // load
            7'b0010011: decode = 10'b00_1000_0000; // alu-imm
            7'b0100011: decode = 10'b00_0100_0000; // store
            7'b0110011: decode = 10'b00_0010_0000; // R-type
            7'b1100011: decode = 10'b00_0001_0000; // branch
            7'b0010111: decode = 10'b00_0000_1000; // auipc
            7'b0110111: decode = 10'b00_0000_0100; // lui
            7'b1100111: decode = 10'b00_0000_0010; // jalr
            7'b1101111: decode = 10'b00_0000_0001; // jal
            default:    decode = 10'b10_0000_0000; // illegal
        endcase
    endfunction

    state_e      state_q;
    logic [31:0] insn_q;
    logic [9:0]  code_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        exec_en_q;
    logic        fault_q;
    logic [3:0]  ecnt_q;
    logic [7:0]  tcnt_q;

    logic [9:0]  code_d;
    logic [7:0]  tcnt_d;
    logic        exec_last;

    // Next-value helpers shared by the FSM and the pc_load decode.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        code_d    = decode(imem.imem_rdata);
        tcnt_d    = tcnt_q + 8'd1;
        exec_last = (ecnt_q == EXEC_LAST);
    end

    // Sequencer FSM with all state and decoder-facing outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            insn_q      <= NOP_INSN;
            code_q      <= NOP_CODE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'd0;
            exec_en_q   <= 1'b0;
            fault_q     <= 1'b0;
            ecnt_q      <= 4'd0;
            tcnt_q      <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q     <= FETCH;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= pc_i;
                    tcnt_q      <= 8'd0;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        insn_q     <= imem.imem_rdata;
                        code_q     <= code_d;
                        tcnt_q     <= 8'd0;
                        imem_req_q <= 1'b0;
                        ecnt_q     <= 4'd0;
                        if (code_d[9]) begin
                            state_q <= HALT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q   <= EXEC;
                            exec_en_q <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_d;
                        if (tcnt_d == TMO_LIMIT) begin
                            state_q    <= HALT;
                            fault_q    <= 1'b1;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (!exec_last) begin
                        ecnt_q <= ecnt_q + 4'd1;
                    end else if (!stall_i) begin
                        state_q     <= FETCH;
                        ecnt_q      <= 4'd0;
                        exec_en_q   <= 1'b0;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_i;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // pc_load must react to stall in the same cycle, so it is decoded from
    // registered state rather than registered itself.
    assign pc_load_o = (state_q == EXEC) && exec_last && !stall_i;

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign insn_o         = insn_q;
    assign code_o         = code_q;
    assign exec_en_o      = exec_en_q;
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_insn_fetch_seq.sv
// Randomized scoreboard bench for insn_fetch_seq: the driver pushes the
// expected outcome of every instruction it issues; a monitor pops and
// compares each time the sequencer retires an instruction with pc_load.
module tb_insn_fetch_seq;

    localparam int EXEC_CYCLES = 2;
    localparam int ACK_TIMEOUT = 15;
    localparam int N_RANDOM    = 40;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] insn;
        logic [9:0]  code;
        int          fetch_cyc;
        int          exec_cyc;
    } exp_t;

    localparam logic [6:0] OPS [9] = '{7'b0000011, 7'b0010011, 7'b0100011,
                                       7'b0110011, 7'b1100011, 7'b0010111,
                                       7'b0110111, 7'b1100111, 7'b1101111};

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        stall_i;
    logic [31:0] insn_o;
    logic [9:0]  code_o;
    logic        exec_en_o;
    logic        pc_load_o;
    logic        fault_o;

    insn_fetch_seq_if imem_bus ();

    insn_fetch_seq #(.EXEC_CYCLES(EXEC_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (imem_bus),
        .pc_i      (pc_i),
        .stall_i   (stall_i),
        .insn_o    (insn_o),
        .code_o    (code_o),
        .exec_en_o (exec_en_o),
        .pc_load_o (pc_load_o),
        .fault_o   (fault_o)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: tally FETCH/EXEC cycles and score each retired instruction.
    int          mon_fcnt = 0;
    int          mon_ecnt = 0;
    logic [31:0] mon_addr = 32'd0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            mon_fcnt = 0;
            mon_ecnt = 0;
        end else begin
            if (imem_bus.imem_req) begin
                mon_fcnt++;
                mon_addr = imem_bus.imem_addr;
            end
            if (exec_en_o) mon_ecnt++;
            if (pc_load_o) begin
                if (sb_q.size() == 0) begin
                    check("pc_load_unexpected", 32'(pc_load_o), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("fetch_addr", mon_addr, e.addr);
                    check("insn", insn_o, e.insn);
                    check("code", 32'(code_o), 32'(e.code));
                    check("code_onehot", 32'($onehot(code_o)), 32'd1);
                    check("fetch_cycles", 32'(mon_fcnt), 32'(e.fetch_cyc));
                    check("exec_cycles", 32'(mon_ecnt), 32'(e.exec_cyc));
                end
                mon_fcnt = 0;
                mon_ecnt = 0;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_insn"}, insn_o, 32'h0000_0013);
        check({tag, "_code"}, 32'(code_o), 32'h080);
        check({tag, "_req"}, 32'(imem_bus.imem_req), 32'd0);
        check({tag, "_addr"}, imem_bus.imem_addr, 32'd0);
        check({tag, "_exec_en"}, 32'(exec_en_o), 32'd0);
        check({tag, "_pc_load"}, 32'(pc_load_o), 32'd0);
        check({tag, "_fault"}, 32'(fault_o), 32'd0);
    endtask

    // Reset, release one cycle before IDLE ends, and land on the first FETCH negedge.
    task automatic apply_reset(input logic [31:0] start_pc);
        @(negedge clk);
        rst_n               = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        stall_i             = 1'b0;
        pc_i                = start_pc;
        sb_q.delete();
        #1;
        check_reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_cycle_req", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        check("fetch_entry_req", 32'(imem_bus.imem_req), 32'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_bus.imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_bus.imem_req) check("wait_req_timeout", 32'd0, 32'd1);
    endtask

    // Answer a FETCH after d idle cycles; returns on the first cycle after the ack edge.
    task automatic do_fetch(input logic [31:0] word, input int d);
        wait_req();
        pc_i = $urandom();
        for (int i = 0; i < d; i++) begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = $urandom();
            stall_i             = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clk);
    endtask

    // Drive EXEC: junk on stall/ack early, then s stall cycles in the last cycle.
    task automatic do_exec(input int s);
        for (int i = 0; i < EXEC_CYCLES - 1; i++) begin
            stall_i             = 1'($urandom_range(0, 1));
            imem_bus.imem_ack   = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom();
            @(negedge clk);
        end
        imem_bus.imem_ack   = 1'($urandom_range(0, 1));
        imem_bus.imem_rdata = $urandom();
        for (int i = 0; i < s; i++) begin
            stall_i = 1'b1;
            @(negedge clk);
        end
        stall_i = 1'b0;
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] word;
        logic [31:0] rnd;
        logic [9:0]  code;
        int          d;
        int          s;
        int          k;
        int          n;
        exp_t        e;

        rst_n               = 1'b1;
        pc_i                = 32'd0;
        stall_i             = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'd0;

        // Nominal, class sweep, long stall, then random legal traffic.
        cur_pc = 32'h0000_0100;
        apply_reset(cur_pc);
        for (int i = 0; i < N_RANDOM; i++) begin
            rnd = $urandom();
            if (i == 0) begin
                word = 32'h0050_0093;
                d    = 0;
                s    = 0;
            end else begin
                k = (i <= 9) ? i - 1 : int'($urandom_range(0, 8));
                word = {rnd[31:7], OPS[k]};
                d    = (i <= 9) ? 0 : int'($urandom_range(0, 4));
                s    = (i == 10) ? 4 : ((i > 10) ? int'($urandom_range(0, 3)) : 0);
            end
            code = 10'd0;
            for (int j = 0; j < 9; j++)
                if (word[6:0] == OPS[j]) code = 10'd1 << (8 - j);
            e.addr      = cur_pc;
            e.insn      = word;
            e.code      = code;
            e.fetch_cyc = d + 1;
            e.exec_cyc  = EXEC_CYCLES + s;
            sb_q.push_back(e);
            do_fetch(word, d);
            do_exec(s);
            rnd    = $urandom();
            cur_pc = {rnd[31:2], 2'b00};
            pc_i   = cur_pc;
        end
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Illegal opcode: HALT with fault, nothing executed, held while idle inputs wiggle.
        do_fetch(32'h0000_007F, 1);
        #1;
        check("illegal_code", 32'(code_o), 32'h200);
        check("illegal_fault", 32'(fault_o), 32'd1);
        check("illegal_req", 32'(imem_bus.imem_req), 32'd0);
        check("illegal_exec_en", 32'(exec_en_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            stall_i             = 1'($urandom_range(0, 1));
            imem_bus.imem_ack   = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom();
            pc_i                = $urandom();
            @(negedge clk);
            #1;
            check("halt_hold", {insn_o[19:0], code_o, fault_o,
                                imem_bus.imem_req | exec_en_o | pc_load_o},
                  {20'h0007F, 10'h200, 1'b1, 1'b0});
        end

        // Ack timeout: count FETCH cycles until imem_req drops.
        apply_reset(32'h0000_0400);
        n = 1;
        repeat (40) begin
            @(negedge clk);
            if (!imem_bus.imem_req) break;
            n++;
        end
        check("timeout_fetch_cycles", 32'(n), 32'(ACK_TIMEOUT));
        check("timeout_fault", 32'(fault_o), 32'd1);
        check("timeout_req", 32'(imem_bus.imem_req), 32'd0);

        // Half-clock reset pulse mid-EXEC: immediate reset values, then IDLE and FETCH.
        apply_reset(32'h0000_0200);
        do_fetch(32'h0050_0093, 0);
        #1;
        check("exec_before_reset", 32'(exec_en_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #4 rst_n = 1'b1;
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("post_reset_idle_req", 32'(imem_bus.imem_req), 32'd0);
        check("post_reset_no_pc_load", 32'(pc_load_o), 32'd0);
        @(negedge clk);
        check("post_reset_fetch_req", 32'(imem_bus.imem_req), 32'd1);
        check("post_reset_fetch_addr", imem_bus.imem_addr, pc_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
